// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_* family of on-chip memories:
// clear-engine FSM states, read-during-write selectors and a width-generic byte merge.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    localparam int MERGE_MAX_BITS  = 1024;
    localparam int MERGE_MAX_BYTES = MERGE_MAX_BITS / 8;

    // Callers zero-extend into the fixed-width arguments and cast the result back to their width.
    function automatic logic [MERGE_MAX_BITS-1:0] byte_merge(
        input logic [MERGE_MAX_BITS-1:0]  old_word,
        input logic [MERGE_MAX_BITS-1:0]  new_word,
        input logic [MERGE_MAX_BYTES-1:0] be
    );
        logic [MERGE_MAX_BITS-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MERGE_MAX_BYTES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_2port_clr_if.sv
// Port bundle for ram_2port_clr: byte-enabled write port, read port, soft clear and status.
// The requester uses master; the RAM uses slave.
interface ram_2port_clr_if #(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 32
);
    localparam int BE_SIZE = DATA_SIZE / 8;

    logic                 clr_req;
    logic                 wr_en;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [DATA_SIZE-1:0] wr_data;
    logic [BE_SIZE-1:0]   wr_be;
    logic                 rd_en;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [DATA_SIZE-1:0] rd_data;
    logic                 rd_valid;
    logic                 init_busy;

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy
    );

endinterface

// File: rtl/ram_clr_ctrl.sv
// Clear-sweep FSM: owns clr_ptr/init_busy and muxes sweep or user writes onto the array port.
// Latency: sweep is DEPTH cycles; no backpressure, user writes during a sweep are dropped.
module ram_clr_ctrl
    import ram_pkg::*;
#(
    parameter int                   ADDR_SIZE = 4,
    parameter int                   DATA_SIZE = 32,
    parameter logic [DATA_SIZE-1:0] CLR_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_req,
    input  logic                   wr_en,
    input  logic [ADDR_SIZE-1:0]   wr_addr,
    input  logic [DATA_SIZE-1:0]   wr_data,
    input  logic [DATA_SIZE/8-1:0] wr_be,
    output logic                   ready,
    output logic                   init_busy,
    output logic                   mem_we,
    output logic [ADDR_SIZE-1:0]   mem_waddr,
    output logic [DATA_SIZE-1:0]   mem_wdata,
    output logic [DATA_SIZE/8-1:0] mem_wbe
);

    ram_state_e           state;
    logic [ADDR_SIZE-1:0] clr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_ptr   <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_SIZE'(1);
                    if (&clr_ptr) begin
                        state     <= ST_READY;
                        init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (clr_req) begin
                        state     <= ST_CLEAR;
                        clr_ptr   <= '0;
                        init_busy <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_CLEAR;
                    clr_ptr   <= '0;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    assign ready = (state == ST_READY);

    // Reset holds the FSM in CLEAR, so the sweep write must also be held off while rst is high.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
        if (state == ST_CLEAR) begin
            mem_we    = ~rst;
            mem_waddr = clr_ptr;
            mem_wdata = CLR_VALUE;
            mem_wbe   = '1;
        end else begin
            mem_we    = wr_en;
        end
    end

endmodule

// File: rtl/ram_2port_clr.sv
// Simple-dual-port RAM with byte enables, selectable read latency/RDW behaviour and a clear engine.
// Latency: RD_LATENCY (0 or 1); no backpressure, reads and writes are ignored while init_busy=1.
module ram_2port_clr
    import ram_pkg::*;
#(
    parameter int                   ADDR_SIZE  = 4,
    parameter int                   DATA_SIZE  = 32,
    parameter int                   RD_LATENCY = 1,
    parameter int                   RDW_MODE   = 0,
    parameter logic [DATA_SIZE-1:0] CLR_VALUE  = '0
) (
    input  logic             clk,
    input  logic             rst,
    ram_2port_clr_if.slave   bus
);

    localparam int DEPTH   = 1 << ADDR_SIZE;
    localparam int BE_SIZE = DATA_SIZE / 8;

    generate
        if (DATA_SIZE % 8 != 0) begin : g_chk_data
            $fatal(1, "ram_2port_clr: DATA_SIZE must be a multiple of 8");
        end
        if (DATA_SIZE > MERGE_MAX_BITS) begin : g_chk_width
            $fatal(1, "ram_2port_clr: DATA_SIZE exceeds byte_merge width");
        end
        if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_chk_lat
            $fatal(1, "ram_2port_clr: RD_LATENCY must be 0 or 1");
        end
        if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_chk_rdw
            $fatal(1, "ram_2port_clr: RDW_MODE must be 0 or 1");
        end
    endgenerate

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic                 ready;
    logic                 init_busy;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_waddr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [BE_SIZE-1:0]   mem_wbe;

    ram_clr_ctrl #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .CLR_VALUE (CLR_VALUE)
    ) u_clr_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (bus.clr_req),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .wr_be     (bus.wr_be),
        .ready     (ready),
        .init_busy (init_busy),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wbe   (mem_wbe)
    );

    assign bus.init_busy = init_busy;

    // Array has no reset; the clear engine is the only initialiser.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_SIZE; i++) begin
                if (mem_wbe[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    logic                 rd_ok;
    logic                 collide;
    logic [DATA_SIZE-1:0] stored_word;
    logic [DATA_SIZE-1:0] merged_word;
    logic [DATA_SIZE-1:0] rd_word;

    assign rd_ok       = bus.rd_en & ready;
    assign collide     = bus.wr_en & (bus.wr_addr == bus.rd_addr);
    assign stored_word = mem[bus.rd_addr];
    assign merged_word = DATA_SIZE'(byte_merge(MERGE_MAX_BITS'(stored_word),
                                               MERGE_MAX_BITS'(bus.wr_data),
                                               MERGE_MAX_BYTES'(bus.wr_be)));
    assign rd_word     = (RDW_MODE == RDW_NEW && collide) ? merged_word : stored_word;

    generate
        if (RD_LATENCY == 0) begin : g_rd_comb
            assign bus.rd_data  = rd_ok ? rd_word : '0;
            assign bus.rd_valid = rd_ok;
        end else begin : g_rd_reg
            logic [DATA_SIZE-1:0] rd_data_q;
            logic                 rd_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_ok;
                    if (rd_ok) begin
                        rd_data_q <= rd_word;
                    end
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_2port_clr.sv
// Drives four RAM configurations (latency 1/0 x RDW old/new) with one stimulus stream
// and compares each against a word-level array model of the memory and clear sweep.
module tb_ram_2port_clr;

    localparam int NDUT  = 4;
    localparam int DEPTH = 16;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        clr_req = 1'b0;
    logic        wr_en   = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be   = '0;
    logic        rd_en   = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic [31:0] rd_data_o  [NDUT];
    logic        rd_valid_o [NDUT];
    logic        busy_o     [NDUT];

    always #5 clk = ~clk;

    // Instances 0,1: registered read (RDW old/new); 2,3: combinational read (RDW old/new).
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ram_2port_clr_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) bus ();

        assign bus.clr_req = clr_req;
        assign bus.wr_en   = wr_en;
        assign bus.wr_addr = wr_addr;
        assign bus.wr_data = wr_data;
        assign bus.wr_be   = wr_be;
        assign bus.rd_en   = rd_en;
        assign bus.rd_addr = rd_addr;

        ram_2port_clr #(
            .ADDR_SIZE  (4),
            .DATA_SIZE  (32),
            .RD_LATENCY ((g < 2) ? 1 : 0),
            .RDW_MODE   (g % 2),
            .CLR_VALUE  (32'h0000_0000)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign rd_data_o[g]  = bus.rd_data;
        assign rd_valid_o[g] = bus.rd_valid;
        assign busy_o[g]     = bus.init_busy;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory contents, whether the RAM is usable, and the sweep position.
    logic [31:0] ref_mem [DEPTH];
    bit          m_ready;
    int          sweep_idx;
    logic [31:0] exp_q      [NDUT];
    bit          exp_v      [NDUT];
    logic [31:0] comb_seen  [NDUT];

    function automatic bit is_reg(input int k);
        return k < 2;
    endfunction

    function automatic bit is_new(input int k);
        return (k % 2) == 1;
    endfunction

    function automatic logic [31:0] merge_model(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // One clock: drive inputs after negedge, check combinational outputs, clock, check registered.
    task automatic cycle(input logic c_req, input logic w_en, input logic [3:0] w_a,
                         input logic [31:0] w_d, input logic [3:0] w_be,
                         input logic r_en, input logic [3:0] r_a);
        logic [31:0] merged;
        logic [31:0] exp_c;
        bit          same;
        clr_req = c_req;
        wr_en   = w_en;
        wr_addr = w_a;
        wr_data = w_d;
        wr_be   = w_be;
        rd_en   = r_en;
        rd_addr = r_a;
        #1;
        merged = merge_model(ref_mem[w_a], w_d, w_be);
        same   = w_en && (w_a == r_a);
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(!m_ready));
            if (!is_reg(k)) begin
                exp_c = '0;
                if (r_en && m_ready) exp_c = (is_new(k) && same) ? merged : ref_mem[r_a];
                check_eq($sformatf("rd_comb%0d", k), rd_data_o[k], exp_c);
                check_eq($sformatf("vld_comb%0d", k), 32'(rd_valid_o[k]), 32'(r_en && m_ready));
                comb_seen[k] = rd_data_o[k];
            end
        end
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) begin
            if (is_reg(k)) begin
                exp_v[k] = r_en && m_ready;
                if (exp_v[k]) exp_q[k] = (is_new(k) && same) ? merged : ref_mem[r_a];
            end
        end
        if (m_ready && w_en) ref_mem[w_a] = merged;
        if (!m_ready) begin
            ref_mem[sweep_idx] = 32'h0;
            if (sweep_idx == DEPTH - 1) m_ready = 1'b1;
            sweep_idx++;
        end else if (c_req) begin
            m_ready   = 1'b0;
            sweep_idx = 0;
        end
        #1;
        for (int k = 0; k < NDUT; k++) begin
            if (is_reg(k)) begin
                check_eq($sformatf("rd_reg%0d", k), rd_data_o[k], exp_q[k]);
                check_eq($sformatf("vld_reg%0d", k), 32'(rd_valid_o[k]), 32'(exp_v[k]));
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        cycle(1'b0, 1'b1, a, d, be, 1'b0, 4'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        cycle(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b1, a);
    endtask

    task automatic rand_cycle(input bit allow_clr);
        logic [3:0] wa;
        logic [3:0] ra;
        wa = 4'($urandom_range(0, 15));
        ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
        cycle(allow_clr && ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), wa,
              $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ra);
    endtask

    // Runs random traffic while busy is high and checks the sweep took exactly DEPTH cycles.
    task automatic count_sweep(input string tag);
        int cnt;
        cnt = 0;
        while (busy_o[0] === 1'b1 && cnt < 40) begin
            rand_cycle(1'b1);
            cnt++;
        end
        check_eq(tag, 32'(cnt), 32'(DEPTH));
    endtask

    // Asserts reset between edges, checks outputs drop immediately, then holds for two edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        m_ready   = 1'b0;
        sweep_idx = 0;
        for (int k = 0; k < NDUT; k++) begin
            exp_v[k] = 1'b0;
            exp_q[k] = '0;
        end
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("rst_busy%0d", k), 32'(busy_o[k]), 32'd1);
            check_eq($sformatf("rst_vld%0d", k), 32'(rd_valid_o[k]), 32'd0);
            check_eq($sformatf("rst_rd%0d", k), rd_data_o[k], 32'h0);
        end
        @(negedge clk);
        @(negedge clk);
        clr_req = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        for (int k = 0; k < NDUT; k++) begin
            exp_q[k]     = '0;
            exp_v[k]     = 1'b0;
            comb_seen[k] = '0;
        end
        m_ready   = 1'b0;
        sweep_idx = 0;

        // Power-on reset and sweep, then every word reads the clear value.
        @(negedge clk);
        do_reset();
        count_sweep("sweep_len_por");
        for (int a = 0; a < DEPTH; a++) begin
            rd(4'(a));
            check_eq("por_zero_reg", rd_data_o[0], 32'h0);
            check_eq("por_zero_comb", comb_seen[2], 32'h0);
        end

        // Byte-enable merge.
        wr(4'd3, 32'hAABB_CCDD, 4'hF);
        wr(4'd3, 32'h1122_3344, 4'b0101);
        rd(4'd3);
        check_eq("be_merge_reg", rd_data_o[0], 32'hAA22_CC44);
        check_eq("be_merge_comb", comb_seen[3], 32'hAA22_CC44);

        // Same-address read during write.
        wr(4'd5, 32'h1234_5678, 4'hF);
        cycle(1'b0, 1'b1, 4'd5, 32'hCAFE_F00D, 4'hF, 1'b1, 4'd5);
        check_eq("rdw_old_reg", rd_data_o[0], 32'h1234_5678);
        check_eq("rdw_old_vld", 32'(rd_valid_o[0]), 32'd1);
        check_eq("rdw_new_reg", rd_data_o[1], 32'hCAFE_F00D);
        check_eq("rdw_old_comb", comb_seen[2], 32'h1234_5678);
        check_eq("rdw_new_comb", comb_seen[3], 32'hCAFE_F00D);
        rd(4'd5);
        check_eq("rdw_after_old", rd_data_o[0], 32'hCAFE_F00D);
        check_eq("rdw_after_new", rd_data_o[1], 32'hCAFE_F00D);
        cycle(1'b0, 1'b1, 4'd5, 32'h1111_1111, 4'b0011, 1'b1, 4'd5);
        check_eq("rdw_partial_new", rd_data_o[1], 32'hCAFE_1111);
        check_eq("rdw_partial_old", rd_data_o[0], 32'hCAFE_F00D);

        // Combinational read follows rd_addr with no clock edge.
        wr(4'd1, 32'h1, 4'hF);
        wr(4'd2, 32'h2, 4'hF);
        rd_en   = 1'b1;
        rd_addr = 4'd1;
        #1 check_eq("async_a1", rd_data_o[2], 32'h1);
        check_eq("async_vld", 32'(rd_valid_o[2]), 32'd1);
        rd_addr = 4'd2;
        #1 check_eq("async_a2", rd_data_o[3], 32'h2);
        rd_en   = 1'b0;
        #1 check_eq("async_off", rd_data_o[2], 32'h0);
        check_eq("async_off_vld", 32'(rd_valid_o[2]), 32'd0);
        idle_cycle();

        // Soft clear with a write in the request cycle and random traffic during the sweep.
        for (int a = 0; a < DEPTH; a++) wr(4'(a), 32'hFFFF_FFFF, 4'hF);
        cycle(1'b1, 1'b1, 4'd0, 32'h5, 4'hF, 1'b0, 4'd0);
        count_sweep("sweep_len_soft");
        for (int a = 0; a < DEPTH; a++) begin
            rd(4'(a));
            check_eq("soft_zero", rd_data_o[0], 32'h0);
        end

        // Reset with a read pending, and reset seven cycles into a sweep.
        rd(4'd3);
        check_eq("pre_rst_vld", 32'(rd_valid_o[0]), 32'd1);
        do_reset();
        count_sweep("sweep_len_rst_read");
        cycle(1'b1, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
        repeat (7) rand_cycle(1'b0);
        do_reset();
        count_sweep("sweep_len_rst_mid");

        repeat (600) rand_cycle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_2port_clr.md
Name: ram_2port_clr

Overview:
Parametrised simple-dual-port RAM with one write port and one read port on a single clock. It is the successor to the single-port async-read RAM and adds the following:
- byte-enable writes
- selectable read latency (0 = combinational, 1 = registered)
- selectable read-during-write behaviour
- a hardware clear engine that sweeps every word to a constant after reset or on request

It sits behind register files and small packet buffers.

Parameters:
- ADDR_SIZE, 4, address width; depth DEPTH = 1<<ADDR_SIZE.
- DATA_SIZE, 32, word width; must be a multiple of 8; BE_SIZE = DATA_SIZE/8.
- RD_LATENCY, 1, 0 = rd_data combinational from rd_addr; 1 = rd_data registered one cycle after rd_en.
- RDW_MODE, 0, same-address read during write: 0 = old data, 1 = new data (byte-merged forwarding).
- CLR_VALUE, 0, DATA_SIZE-bit value written to every word by the clear engine.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- clr_req  in  1  one-cycle pulse: start a clear sweep (accepted only when init_busy=0).
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_SIZE  write address.
- wr_data  in  DATA_SIZE  write data.
- wr_be  in  BE_SIZE  byte enables; bit i controls wr_data[8i+7:8i].
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_SIZE  read address.
- rd_data  out  DATA_SIZE  read data.
- rd_valid  out  1  rd_data qualifier.
- init_busy  out  1  clear sweep in progress; memory unusable.

Behaviour:
- Reset and clock: one clock, clk; reset rst is asynchronous, active-high.
- While rst=1:
  - FSM forced to CLEAR, clr_ptr=0.
  - init_busy=1, rd_data=0, rd_valid=0.
  - The memory array itself is not reset.
- FSM states are CLEAR and READY.
- CLEAR state:
  - Each clk edge with rst=0 writes CLR_VALUE to mem[clr_ptr] and increments clr_ptr.
  - On the edge that writes address DEPTH-1, go to READY.
  - The sweep takes exactly DEPTH cycles after rst deasserts; init_busy falls in the cycle after the last clear write.
- READY state:
  - clr_req=1 goes to CLEAR with clr_ptr=0 at the next edge.
  - init_busy=1 from that edge onward.
- Clear precedence:
  - During CLEAR, wr_en is ignored (the write is dropped, not queued).
  - rd_en is ignored: rd_valid=0, rd_data=0.
  - clr_req is ignored during CLEAR (no restart).
  - clr_req and wr_en in the same READY cycle: the write still commits that edge, then the sweep overwrites it.
- Write:
  - In READY with wr_en=1, on the edge, byte i of mem[wr_addr] takes wr_data byte i when wr_be[i]=1.
  - Bytes with wr_be[i]=0 are unchanged.
  - wr_be=0 makes the write a no-op.
- Read, RD_LATENCY=0:
  - rd_data = mem[rd_addr] combinationally when rd_en=1 and READY, else 0.
  - rd_valid = rd_en & READY.
  - With RDW_MODE=1 and wr_en & rd_en & wr_addr==rd_addr, rd_data shows the byte-merged new word combinationally.
  - With RDW_MODE=0 it shows the stored word.
- Read, RD_LATENCY=1:
  - On the edge with rd_en=1 in READY, the word is captured into rd_data and rd_valid=1 for the following cycle.
  - With rd_en=0, rd_valid=0 next cycle and rd_data holds its last value.
  - Same-address collision: RDW_MODE=0 captures the pre-write word; RDW_MODE=1 captures the byte-merged post-write word.
- Address wrap: addresses are natural ADDR_SIZE-bit values; no out-of-range case exists.
- Reset mid-sweep or mid-read: the sweep restarts from 0 and any pending rd_valid is cleared immediately.
- Elaboration checks: DATA_SIZE%8 != 0, RD_LATENCY outside {0,1}, or RDW_MODE outside {0,1} is a fatal error.

Decomposition:
- Shared package ram_pkg holds:
  - FSM state enum (ST_CLEAR, ST_READY)
  - RDW_OLD/RDW_NEW constants
  - a byte-merge function (old word, new word, byte enables -> merged word), reused by future RAM variants
- One sub-module, ram_clr_ctrl, holds the FSM, clr_ptr and init_busy, and outputs the effective write enable, address and data mux to the array.

Test Plan:
1. Reset then sweep (ADDR_SIZE=4): pulse rst, release; init_busy=1 for exactly 16 cycles, then 0. Read all 16 addresses -> each 32'h0000_0000 (CLR_VALUE=0).
2. Byte enables: write 0xAABBCCDD to addr 3 with wr_be=4'hF, then 0x11223344 with wr_be=4'b0101. Read addr 3 -> 0xAA22CC44.
3. Read-during-write, RD_LATENCY=1: addr 5 holds 0x12345678; same cycle write 0xCAFEF00D (be=F) and read addr 5.
   - RDW_MODE=0 -> next cycle rd_data=0x12345678, rd_valid=1.
   - RDW_MODE=1 -> 0xCAFEF00D.
   - Either way, a later read returns 0xCAFEF00D.
4. Async read, RD_LATENCY=0: change rd_addr between addrs 1 and 2 (holding 0x1, 0x2) with rd_en=1 -> rd_data follows in the same cycle with no clock edge; rd_en=0 -> rd_data=0, rd_valid=0.
5. Soft clear with traffic: fill all words with 0xFFFFFFFF, pulse clr_req together with a write of 0x5 to addr 0. Writes issued during the sweep are dropped, rd_valid stays 0, init_busy is high 16 cycles, and afterwards all words (including addr 0) read 0.
6. Reset mid-sweep: assert rst 7 cycles into a sweep (async, between edges) -> init_busy stays 1, rd_valid drops to 0 immediately. After release, the full 16-cycle sweep reruns from address 0.
